// File: rtl/rv32imc_types.sv
// Shared opcode encoding and helpers for the iterative execute ALU.
package rv32imc_types;

    localparam int unsigned XALU_TAG_W = 5;

    // op[4:3]: 00 base, 01 multiply, 10 divide
    typedef enum logic [4:0] {
        alu_add    = 5'b00000,
        alu_sub    = 5'b00001,
        alu_sll    = 5'b00010,
        alu_srl    = 5'b00011,
        alu_sra    = 5'b00100,
        alu_xor    = 5'b00101,
        alu_or     = 5'b00110,
        alu_and    = 5'b00111,
        mul_mul    = 5'b01000,
        mul_mulh   = 5'b01001,
        mul_mulhsu = 5'b01010,
        mul_mulhu  = 5'b01011,
        div_div    = 5'b10000,
        div_divu   = 5'b10001,
        div_rem    = 5'b10010,
        div_remu   = 5'b10011
    } xalu_op_t;

    function automatic logic is_mul(input logic [4:0] op);
        return op[4:2] == 3'b010;
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return op[4:2] == 3'b100;
    endfunction

    function automatic logic op_legal(input logic [4:0] op);
        return (op[4:3] == 2'b00) || is_mul(op) || is_div(op);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Bit-serial multiply (shift-add) and restoring divide on operand magnitudes,
// sharing one 2*WIDTH register; the sign is applied on the final iteration.
module alu_iter_muldiv
    import rv32imc_types::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             start,
    input  logic             step,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last_c,
    output logic [WIDTH-1:0] res_c
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned W2 = 2 * WIDTH;

    logic [W2-1:0]    acc;
    logic [WIDTH-1:0] opnd;
    logic [CW-1:0]    cnt;
    logic             neg;
    logic             mul_mode;
    logic             hi_sel;
    logic             rem_sel;

    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             ld_neg;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl;
    logic [WIDTH:0]   diff;
    logic             qbit;
    logic [W2-1:0]    nxt;
    logic [W2-1:0]    prod;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    // Operand signs, magnitudes and result sign captured at accept
    always_comb begin
        sa     = a[WIDTH-1] & (op == mul_mulh || op == mul_mulhsu || op == div_div || op == div_rem);
        sb     = b[WIDTH-1] & (op == mul_mulh || op == div_div || op == div_rem);
        mag_a  = sa ? -a : a;
        mag_b  = sb ? -b : b;
        ld_neg = (op == div_rem) ? sa : (sa ^ sb);
    end

    // One iteration of either algorithm plus the signed final result
    always_comb begin
        sum  = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        shl  = {acc[W2-1:WIDTH], acc[WIDTH-1]};
        diff = shl - {1'b0, opnd};
        qbit = ~diff[WIDTH];
        if (mul_mode) begin
            nxt = {sum, acc[WIDTH-1:1]};
        end else begin
            nxt = {(qbit ? diff[WIDTH-1:0] : shl[WIDTH-1:0]), acc[WIDTH-2:0], qbit};
        end
        prod = neg ? -nxt : nxt;
        quo  = neg ? -nxt[WIDTH-1:0] : nxt[WIDTH-1:0];
        rem  = neg ? -nxt[W2-1:WIDTH] : nxt[W2-1:WIDTH];
        if (mul_mode) begin
            res_c = hi_sel ? prod[W2-1:WIDTH] : prod[WIDTH-1:0];
        end else begin
            res_c = rem_sel ? rem : quo;
        end
        last_c = step & (cnt == CW'(WIDTH - 1));
    end

    // Load on accept, advance one bit per busy cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            opnd     <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            mul_mode <= 1'b0;
            hi_sel   <= 1'b0;
            rem_sel  <= 1'b0;
        end else if (clear) begin
            cnt <= '0;
        end else if (start) begin
            cnt      <= '0;
            neg      <= ld_neg;
            mul_mode <= is_mul(op);
            hi_sel   <= (op != mul_mul);
            rem_sel  <= op[1];
            acc      <= is_mul(op) ? {{WIDTH{1'b0}}, mag_b} : {{WIDTH{1'b0}}, mag_a};
            opnd     <= is_mul(op) ? mag_a : mag_b;
        end else if (step) begin
            acc <= nxt;
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/alu_iter.sv
// Execute-stage ALU: single-cycle base ops and divide corner cases,
// iterative RV M-extension multiply/divide, valid/ready on both sides.
module alu_iter
    import rv32imc_types::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic [4:0]            op,
    input  logic [XALU_TAG_W-1:0] tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      f,
    output logic [XALU_TAG_W-1:0] out_tag
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] smin = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] st_idle = 2'd0;
    localparam logic [1:0] st_busy = 2'd1;
    localparam logic [1:0] st_done = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_n;
    logic [WIDTH-1:0]      f_n;
    logic [XALU_TAG_W-1:0] tag_n;

    logic                  accept;
    logic                  div_zero;
    logic                  div_ovf;
    logic                  div_fast;
    logic                  md_go;
    logic [WIDTH-1:0]      base_c;
    logic [WIDTH-1:0]      fast_c;
    logic                  md_last_c;
    logic [WIDTH-1:0]      md_res_c;

    assign in_ready  = ~flush & ((state == st_idle) | ((state == st_done) & out_ready));
    assign out_valid = (state == st_done);
    assign accept    = in_valid & in_ready;

    // Single-cycle results: base ops and divide special cases
    always_comb begin
        case (op)
            alu_sub: base_c = a - b;
            alu_sll: base_c = a << b[SHW-1:0];
            alu_srl: base_c = a >> b[SHW-1:0];
            alu_sra: base_c = $signed(a) >>> b[SHW-1:0];
            alu_xor: base_c = a ^ b;
            alu_or:  base_c = a | b;
            alu_and: base_c = a & b;
            default: base_c = a + b;
        endcase
        div_zero = (b == '0);
        div_ovf  = (op == div_div || op == div_rem) && (a == smin) && (b == '1);
        div_fast = is_div(op) && (div_zero || div_ovf);
        md_go    = is_mul(op) || (is_div(op) && !div_fast);
        fast_c   = base_c;
        if (div_fast) begin
            if (div_zero) begin
                fast_c = op[1] ? a : '1;
            end else begin
                fast_c = op[1] ? '0 : smin;
            end
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_n = state;
        f_n     = f;
        tag_n   = out_tag;
        if (flush) begin
            state_n = st_idle;
        end else if (accept) begin
            state_n = md_go ? st_busy : st_done;
            tag_n   = tag;
            if (!md_go) begin
                f_n = fast_c;
            end
        end else begin
            case (state)
                st_idle: state_n = st_idle;
                st_busy: begin
                    if (md_last_c) begin
                        state_n = st_done;
                        f_n     = md_res_c;
                    end
                end
                st_done: begin
                    if (out_ready) begin
                        state_n = st_idle;
                    end
                end
                default: state_n = st_idle;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= st_idle;
            f       <= '0;
            out_tag <= '0;
        end else begin
            state   <= state_n;
            f       <= f_n;
            out_tag <= tag_n;
        end
    end

    alu_iter_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .start (accept),
        .step  (state == st_busy),
        .op    (op),
        .a     (a),
        .b     (b),
        .last_c(md_last_c),
        .res_c (md_res_c)
    );

    // Unknown opcodes execute as add; flag them in simulation
    illegal_op_chk: assert property (@(posedge clk) disable iff (rst) accept |-> op_legal(op));

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: directed corner cases then random traffic.
module tb_alu_iter;
    import rv32imc_types::*;

    localparam int unsigned W   = 32;
    localparam int unsigned SHW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [4:0]    op;
    logic [4:0]    tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  f;
    logic [4:0]    out_tag;

    typedef struct {
        logic [W-1:0] f;
        logic [4:0]   tag;
        int           acc;
        int           lat;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic acc_last;
    logic mon_v;
    logic mon_r;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    alu_iter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .tag      (tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .f        (f),
        .out_tag  (out_tag)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on wide values
    function automatic logic [W-1:0] ref_f(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0]  sx, zx, sy, zy, p;
        logic signed [W-1:0] xs, ys;
        logic [W-1:0]    mn;
        mn = '0;
        mn[W-1] = 1'b1;
        xs = x;
        ys = y;
        sx = {{W{x[W-1]}}, x};
        zx = {{W{1'b0}}, x};
        sy = {{W{y[W-1]}}, y};
        zy = {{W{1'b0}}, y};
        case (o)
            alu_sub:    return x - y;
            alu_sll:    return x << y[SHW-1:0];
            alu_srl:    return x >> y[SHW-1:0];
            alu_sra:    return W'(xs >>> y[SHW-1:0]);
            alu_xor:    return x ^ y;
            alu_or:     return x | y;
            alu_and:    return x & y;
            mul_mul:    begin p = zx * zy; return p[W-1:0];     end
            mul_mulh:   begin p = sx * sy; return p[2*W-1:W];   end
            mul_mulhsu: begin p = sx * zy; return p[2*W-1:W];   end
            mul_mulhu:  begin p = zx * zy; return p[2*W-1:W];   end
            div_div: begin
                if (y == '0) return '1;
                if (x == mn && y == '1) return mn;
                return W'(xs / ys);
            end
            div_divu:   return (y == '0) ? '1 : x / y;
            div_rem: begin
                if (y == '0) return x;
                if (x == mn && y == '1) return '0;
                return W'(xs % ys);
            end
            div_remu:   return (y == '0) ? x : x % y;
            default:    return x + y;
        endcase
    endfunction

    function automatic int ref_lat(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] mn;
        mn = '0;
        mn[W-1] = 1'b1;
        if (o[4:3] == 2'b01) return W + 1;
        if (o[4:3] == 2'b10) begin
            if (y == '0) return 1;
            if ((o == div_div || o == div_rem) && x == mn && y == '1) return 1;
            return W + 1;
        end
        return 1;
    endfunction

    function automatic logic [4:0] pick_op();
        int i;
        i = $urandom_range(0, 15);
        return (i < 12) ? 5'(i) : 5'(i + 4);
    endfunction

    function automatic logic [W-1:0] rnd_opnd();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return W'($urandom_range(1, 15));
            default: return W'(r);
        endcase
    endfunction

    // Monitor: compares handshake and result against the scoreboard head
    always @(negedge clk) begin
        #3;
        if (rst) begin
            q.delete();
        end else begin
            mon_v = (q.size() != 0) && (cyc >= q[0].acc + q[0].lat);
            mon_r = !flush && ((q.size() == 0) || (mon_v && out_ready));
            chk("out_valid", 64'(out_valid), 64'(mon_v));
            chk("in_ready", 64'(in_ready), 64'(mon_r));
            if (mon_v) begin
                chk("f", 64'(f), 64'(q[0].f));
                chk("out_tag", 64'(out_tag), 64'(q[0].tag));
            end
            if (flush) begin
                q.delete();
            end else if (mon_v && out_ready) begin
                void'(q.pop_front());
            end
        end
    end

    // One cycle of stimulus; records the expected result on accept
    task automatic tick();
        #4;
        acc_last = !rst && in_valid && in_ready;
        if (acc_last) begin
            q.push_back('{f: ref_f(op, a, b), tag: tag, acc: cyc, lat: ref_lat(op, a, b)});
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input logic [4:0] t);
        op       = o;
        a        = x;
        b        = y;
        tag      = t;
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (acc_last) break;
        end
        if (!acc_last) begin
            n_vec++;
            n_bad++;
            $display("FAIL issue_timeout op %h: got no accept, want accept", o);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (q.size() == 0) break;
            tick();
        end
        if (q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending, want 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = alu_add;
        a         = '0;
        b         = '0;
        tag       = '0;
        @(negedge clk);
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_f", 64'(f), 64'd0);
        chk("reset_tag", 64'(out_tag), 64'd0);

        // Base ops and fast-path divides
        issue(alu_sub, W'(5), W'(7), 5'd1);
        issue(alu_sra, 32'h8000_0000, 32'h24, 5'd2);
        issue(mul_mulh, '1, W'(2), 5'd3);
        issue(mul_mulhu, '1, W'(2), 5'd4);
        issue(div_div, 32'h8000_0000, '1, 5'd5);
        issue(div_rem, 32'h1234, '0, 5'd6);
        drain();

        // Backpressure on an iterative divide, then back-to-back accept
        out_ready = 1'b0;
        issue(div_divu, W'(100), W'(7), 5'd7);
        repeat (W + 6) tick();
        chk("bp_f", 64'(f), 64'd14);
        chk("bp_tag", 64'(out_tag), 64'd7);
        out_ready = 1'b1;
        op        = alu_add;
        a         = W'(3);
        b         = W'(4);
        tag       = 5'd8;
        in_valid  = 1'b1;
        tick();
        chk("b2b_accept", 64'(acc_last), 64'd1);
        drain();

        // Flush mid-iteration discards the result
        issue(div_remu, W'(12345), W'(77), 5'd9);
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        flush    = 1'b1;
        in_valid = 1'b1;
        tick();
        chk("flush_blocks_accept", 64'(acc_last), 64'd0);
        flush    = 1'b0;
        in_valid = 1'b0;
        issue(alu_xor, 32'hA5A5_0F0F, 32'h0FF0_1234, 5'd11);
        drain();

        // Reset in the middle of a multiply
        issue(mul_mul, W'(123), W'(456), 5'd10);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midop_reset_f", 64'(f), 64'd0);
        chk("midop_reset_tag", 64'(out_tag), 64'd0);
        chk("midop_reset_valid", 64'(out_valid), 64'd0);

        // Random traffic with backpressure and occasional flush
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            op        = pick_op();
            a         = rnd_opnd();
            b         = rnd_opnd();
            tag       = 5'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            tick();
        end
        drain();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
